// File: rtl/reg_file_ctrl.sv
// Register file controller: request/response port over a byte-laned word memory,
// with a clear sweep after reset or clr_req. Define REG_FILE_CTRL_BYTE_EN_EN to honour req_be.
module reg_file_ctrl #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  input  logic                clr_req,
  output logic                busy
);

  localparam int unsigned       NB       = DATA_W / 8;
  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    RSP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_wr_q, rsp_wr_d;

  logic                can_take;
  logic                accept;
  logic                clearing;
  logic [ADDR_W-1:0]   wr_addr;
  logic [NB-1:0]       be_eff;
  logic [DATA_W-1:0]   rd_word;

`ifdef REG_FILE_CTRL_BYTE_EN_EN
  assign be_eff = req_be;
`else
  logic unused_be;
  assign unused_be = ^req_be;
  assign be_eff    = '1;
`endif

  // A slot is free when idle, or when the held response leaves at this edge.
  assign can_take  = (state_q == IDLE) || ((state_q == RSP) && rsp_ready);
  assign req_ready = can_take && !clr_req;
  assign accept    = req_valid && req_ready;
  assign clearing  = (state_q == CLEAR);
  assign wr_addr   = clearing ? clr_addr_q : req_addr;

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_wr_d    = rsp_wr_q;
    case (state_q)
      CLEAR: begin
        rsp_valid_d = 1'b0;
        clr_addr_d  = clr_addr_q + 1'b1;
        if (clr_addr_q == ADDR_MAX) begin
          state_d = IDLE;
        end
      end
      default: begin
        if (clr_req && can_take) begin
          state_d     = CLEAR;
          clr_addr_d  = '0;
          rsp_valid_d = 1'b0;
        end else if (accept) begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_wr_d    = req_we;
        end else if ((state_q == RSP) && rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wr_q    <= rsp_wr_d;
    end
  end

  // One narrow RAM per byte lane so byte enables map onto plain write enables.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] wbyte;
      logic [7:0] rd_q;
      logic       we_lane;

      assign wbyte   = clearing ? INIT_VAL[8*gi +: 8] : req_wdata[8*gi +: 8];
      assign we_lane = clearing || (accept && req_we && be_eff[gi]);

      always_ff @(posedge clk) begin
        if (we_lane) begin
          mem[wr_addr] <= wbyte;
        end
        if (accept && !req_we) begin
          rd_q <= mem[req_addr];
        end
      end

      assign rd_word[8*gi +: 8] = rd_q;
    end
  endgenerate

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = (rsp_valid_q && !rsp_wr_q) ? rd_word : '0;
  assign busy      = clearing;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Bench for reg_file_ctrl: directed vector table, hand-written corner sequences,
// then random traffic checked against an array-based reference model.
module tb_reg_file_ctrl;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int DEPTH = 256;
  localparam logic [DW-1:0] INIT = 16'h0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [1:0]    req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          clr_req;
  logic          busy;

  int total = 0;
  int bad = 0;

  reg_file_ctrl #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(INIT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .clr_req(clr_req), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = 2'b11; clr_req = 1'b0; rsp_ready = 1'b1;
  endtask

  task automatic wait_sweep(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      @(posedge clk); #2;
      n++;
    end
    if (busy) chk({name, "_timeout"}, 32'(busy), 32'd0);
  endtask

  // One complete transaction with rsp_ready held high.
  task automatic do_txn(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                        input logic [1:0] be, output logic vld, output logic [15:0] rd);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = 1'b1;
    #1;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk("txn_accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1;
    vld = rsp_valid;
    rd  = rsp_rdata;
    $display("txn we=%0d addr=%02h wdata=%04h be=%b -> valid=%0d rdata=%04h", we, addr, wdata, be, vld, rd);
    @(posedge clk); #1;
  endtask

  logic [15:0] mem_m [DEPTH];
  int          sweep_left;
  logic        pending;
  logic [15:0] pend_data;

  initial begin
    logic        v;
    logic [15:0] r;
    logic [15:0] bp_exp;
    int          n;

`ifdef REG_FILE_CTRL_BYTE_EN_EN
    bp_exp = 16'hBE34;
`else
    bp_exp = 16'h1234;
`endif
    tbl[0]  = '{1'b1, 8'h10, 16'hBEEF, 2'b11, 16'h0000};
    tbl[1]  = '{1'b0, 8'h10, 16'h0000, 2'b11, 16'hBEEF};
    tbl[2]  = '{1'b1, 8'h10, 16'h1234, 2'b01, 16'h0000};
    tbl[3]  = '{1'b0, 8'h10, 16'h0000, 2'b11, bp_exp};
    tbl[4]  = '{1'b0, 8'h7F, 16'h0000, 2'b11, 16'h0000};
    tbl[5]  = '{1'b1, 8'hFF, 16'hA5A5, 2'b10, 16'h0000};
`ifdef REG_FILE_CTRL_BYTE_EN_EN
    tbl[6]  = '{1'b0, 8'hFF, 16'h0000, 2'b11, 16'hA500};
`else
    tbl[6]  = '{1'b0, 8'hFF, 16'h0000, 2'b11, 16'hA5A5};
`endif
    tbl[7]  = '{1'b1, 8'h00, 16'h0001, 2'b11, 16'h0000};
    tbl[8]  = '{1'b1, 8'h01, 16'h0002, 2'b11, 16'h0000};
    tbl[9]  = '{1'b1, 8'h02, 16'h0003, 2'b11, 16'h0000};
    tbl[10] = '{1'b1, 8'h03, 16'h0004, 2'b11, 16'h0000};
    tbl[11] = '{1'b0, 8'h02, 16'h0000, 2'b11, 16'h0003};

    // Reset, abort the sweep midway with a second reset, then time the full sweep.
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    n = 0;
    while (busy && n < 2000) begin
      clr_req = (n == 100);
      @(posedge clk); #2;
      n++;
    end
    clr_req = 1'b0;
    $display("sweep busy cycles=%0d", n);
    chk("sweep_busy_cycles", 32'(n), 32'd256);

    for (int i = 0; i < 12; i++) begin
      do_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, v, r);
      chk($sformatf("tbl%0d_valid", i), 32'(v), 32'd1);
      chk($sformatf("tbl%0d_rdata", i), 32'(r), 32'(tbl[i].exp));
    end

    // Back-to-back reads 0..3, one response per cycle.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h00; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("b2b%0d_ready", k), 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      if (k == 3) req_valid = 1'b0;
      else req_addr = 8'(k + 1);
      #1;
      $display("b2b k=%0d valid=%0d rdata=%04h", k, rsp_valid, rsp_rdata);
      chk($sformatf("b2b%0d_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("b2b%0d_rdata", k), 32'(rsp_rdata), 32'(k + 1));
    end
    @(posedge clk); #1;
    chk("b2b_drain", 32'(rsp_valid), 32'd0);

    // Read immediately after a write to the same address.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h05; req_wdata = 16'h5A5A; req_be = 2'b11;
    @(posedge clk); #1;
    req_we = 1'b0;
    #1;
    chk("raw_wr_rdata", 32'(rsp_rdata), 32'd0);
    chk("raw_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1;
    $display("raw read valid=%0d rdata=%04h", rsp_valid, rsp_rdata);
    chk("raw_rd_rdata", 32'(rsp_rdata), 32'h5A5A);
    @(posedge clk); #1;

    // Backpressure: response held for 5 cycles while another request waits.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_addr = 8'h11;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d_rdata", k), 32'(rsp_rdata), 32'(bp_exp));
      chk($sformatf("bp%0d_ready", k), 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_consumed", 32'(rsp_valid), 32'd0);

    // clr_req pulse that drops before the held response is consumed is dropped.
    req_valid = 1'b1; req_addr = 8'h10; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; clr_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("defer_busy_held", 32'(busy), 32'd0);
    clr_req = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("defer_dropped_busy", 32'(busy), 32'd0);
    chk("defer_dropped_valid", 32'(rsp_valid), 32'd0);

    // clr_req still high when the response is consumed starts the sweep.
    req_valid = 1'b1; req_addr = 8'h10; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; clr_req = 1'b1;
    @(posedge clk); #1;
    chk("defer_wait_busy", 32'(busy), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    #1;
    chk("defer_taken_busy", 32'(busy), 32'd1);
    chk("defer_taken_valid", 32'(rsp_valid), 32'd0);
    wait_sweep("defer_sweep");
    do_txn(1'b1, 8'h10, 16'hC0DE, 2'b11, v, r);

    // Reset with a pending response discards it.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_pend_valid", 32'(rsp_valid), 32'd0);
    chk("rst_pend_busy", 32'(busy), 32'd1);
    rsp_ready = 1'b1;
    wait_sweep("rst_pend_sweep");

    // clr_req and req_valid together in IDLE: clear wins.
    do_txn(1'b1, 8'h10, 16'hC0DE, 2'b11, v, r);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_wdata = 16'h7777; clr_req = 1'b1;
    #1;
    chk("coll_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; clr_req = 1'b0;
    #1;
    chk("coll_busy", 32'(busy), 32'd1);
    chk("coll_valid", 32'(rsp_valid), 32'd0);
    wait_sweep("coll_sweep");
    do_txn(1'b0, 8'h20, 16'h0000, 2'b11, v, r);
    chk("coll_rd20", 32'(r), 32'(INIT));
    do_txn(1'b0, 8'h10, 16'h0000, 2'b11, v, r);
    chk("coll_rd10", 32'(r), 32'(INIT));

    // Random traffic against the reference model; memory is all INIT here.
    for (int i = 0; i < DEPTH; i++) mem_m[i] = INIT;
    sweep_left = 0; pending = 1'b0; pend_data = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic       can_take;
      logic [1:0] be_m;
      req_valid = ($urandom_range(0, 9) < 6);
      req_we    = $urandom_range(0, 1) == 1;
      req_addr  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      req_wdata = 16'($urandom);
      req_be    = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 9) < 7);
      clr_req   = ($urandom_range(0, 299) == 0);
      #1;
      can_take = (sweep_left == 0) && (!pending || rsp_ready);
      chk("rnd_ready", 32'(req_ready), 32'(can_take && !clr_req));
      chk("rnd_busy", 32'(busy), 32'(sweep_left > 0));
      chk("rnd_valid", 32'(rsp_valid), 32'(pending));
      if (pending) chk("rnd_rdata", 32'(rsp_rdata), 32'(pend_data));
      @(posedge clk);
`ifdef REG_FILE_CTRL_BYTE_EN_EN
      be_m = req_be;
`else
      be_m = 2'b11;
`endif
      if (sweep_left > 0) begin
        mem_m[DEPTH - sweep_left] = INIT;
        sweep_left--;
      end else if (clr_req && can_take) begin
        sweep_left = DEPTH;
        pending = 1'b0;
      end else if (req_valid && can_take) begin
        if (req_we) begin
          for (int b = 0; b < 2; b++)
            if (be_m[b]) mem_m[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
          pend_data = '0;
        end else begin
          pend_data = mem_m[req_addr];
        end
        pending = 1'b1;
        $display("rnd cyc=%0d we=%0d addr=%02h wdata=%04h be=%b exp_rdata=%04h", cyc, req_we, req_addr, req_wdata, req_be, pend_data);
      end else if (pending && rsp_ready) begin
        pending = 1'b0;
      end
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
